// File: rtl/arf_mp.sv
// arf_mp: multi-port register file with busy scoreboard and a DEPTH-cycle bulk-clear engine; reads are combinational.
// Writes/allocs land on the next edge. o_ready=0 while clearing; inputs are dropped then. Bypass: ARF_MP_BYPASS_EN.
module arf_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int NUM_WR   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_re,
  input  logic [NUM_RD*AW-1:0]   i_rs_addr,
  output logic [NUM_RD*XLEN-1:0] o_rs_data,
  output logic [NUM_RD-1:0]      o_rs_busy,
  input  logic [NUM_WR-1:0]      i_wr,
  input  logic [NUM_WR*AW-1:0]   i_rd_addr,
  input  logic [NUM_WR*XLEN-1:0] i_wr_data,
  input  logic                   i_alloc,
  input  logic [AW-1:0]          i_alloc_rd,
  input  logic                   i_clear,
  output logic                   o_ready
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  function automatic logic is_zreg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign o_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        // Ascending port order lets the highest-indexed writer win.
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr[w] && !is_zreg(i_rd_addr[w*AW +: AW])) begin
            mem_d[i_rd_addr[w*AW +: AW]]  = i_wr_data[w*XLEN +: XLEN];
            busy_d[i_rd_addr[w*AW +: AW]] = 1'b0;
          end
        end
        if (i_alloc && !is_zreg(i_alloc_rd)) begin
          busy_d[i_alloc_rd] = 1'b1;
        end
        if (i_clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_d[idx_q]  = '0;
        busy_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rbusy;
    o_rs_data = '0;
    o_rs_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra    = i_rs_addr[k*AW +: AW];
      rdat  = mem_q[ra];
      rbusy = busy_q[ra];
`ifdef ARF_MP_BYPASS_EN
      if ((state_q == ST_IDLE) && !is_zreg(ra)) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (i_wr[w] && (i_rd_addr[w*AW +: AW] == ra)) begin
            rdat  = i_wr_data[w*XLEN +: XLEN];
            rbusy = i_alloc && (i_alloc_rd == ra);
          end
        end
      end
`endif
      if (is_zreg(ra)) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
      if (!i_re) begin
        rdat = '0;
      end
      if (state_q == ST_CLEAR) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
      o_rs_data[k*XLEN +: XLEN] = rdat;
      o_rs_busy[k]              = rbusy;
    end
  end

endmodule

// File: tb/tb_arf_mp.sv
// Scoreboard bench for arf_mp (NUM_WR=2): stimulus queues expected read-port values, a negedge monitor compares.
module tb_arf_mp;

`ifdef ARF_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_re;
  logic [9:0]  i_rs_addr;
  logic [63:0] o_rs_data;
  logic [1:0]  o_rs_busy;
  logic [1:0]  i_wr;
  logic [9:0]  i_rd_addr;
  logic [63:0] i_wr_data;
  logic        i_alloc;
  logic [4:0]  i_alloc_rd;
  logic        i_clear;
  logic        o_ready;

  always #5 clk = ~clk;

  arf_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .i_re(i_re), .i_rs_addr(i_rs_addr),
    .o_rs_data(o_rs_data), .o_rs_busy(o_rs_busy), .i_wr(i_wr),
    .i_rd_addr(i_rd_addr), .i_wr_data(i_wr_data), .i_alloc(i_alloc),
    .i_alloc_rd(i_alloc_rd), .i_clear(i_clear), .o_ready(o_ready)
  );

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  logic sample = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always @(negedge clk) begin
    if (sample) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_sample: scoreboard empty");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({o_rs_data[31:0], o_rs_data[63:32], o_rs_busy, o_ready} !== {e.d0, e.d1, e.busy, e.rdy}) begin
          n_bad++;
          $display("FAIL %s: got d0=%h d1=%h busy=%b rdy=%b, want d0=%h d1=%h busy=%b rdy=%b",
                   e.name, o_rs_data[31:0], o_rs_data[63:32], o_rs_busy, o_ready,
                   e.d0, e.d1, e.busy, e.rdy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] busy, input logic rdy);
    exp_t e;
    e.name = name; e.d0 = d0; e.d1 = d1; e.busy = busy; e.rdy = rdy;
    exp_q.push_back(e);
    sample = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    i_rs_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] we, input logic [4:0] w0, input logic [31:0] d0,
                    input logic [4:0] w1, input logic [31:0] d1);
    i_wr      = we;
    i_rd_addr = {w1, w0};
    i_wr_data = {d1, d0};
  endtask

  task automatic idle();
    i_wr    = 2'b00;
    i_alloc = 1'b0;
    i_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_re = 1'b1; i_rs_addr = '0; i_rd_addr = '0; i_wr_data = '0;
    i_wr = '0; i_alloc = 1'b0; i_alloc_rd = '0; i_clear = 1'b0;
    tick();
    rst = 1'b0;
    rd(5'd0, 5'd1);
    chk("reset", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();

    wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0); rd(5'd5, 5'd0);
    chk("wr_same_cycle", BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    idle();
    chk("wr_read", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
    tick();

    wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0); rd(5'd0, 5'd0);
    chk("x0_bypass", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    idle(); rd(5'd0, 5'd5);
    chk("x0_read", 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    tick();

    wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22); rd(5'd7, 5'd5);
    chk("dual_wr_same", BYP ? 32'h22 : 32'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    tick();
    idle();
    chk("dual_wr_read", 32'h22, 32'hDEADBEEF, 2'b00, 1'b1);
    tick();

    wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0); i_alloc = 1'b1; i_alloc_rd = 5'd3; rd(5'd3, 5'd0);
    chk("alloc_wr_same", BYP ? 32'h33 : 32'h0, 32'h0, BYP ? 2'b01 : 2'b00, 1'b1);
    tick();
    idle();
    chk("alloc_wins", 32'h33, 32'h0, 2'b01, 1'b1);
    tick();
    wr(2'b10, 5'd0, 32'h0, 5'd3, 32'h44);
    chk("wr_clr_busy_same", BYP ? 32'h44 : 32'h33, 32'h0, BYP ? 2'b00 : 2'b01, 1'b1);
    tick();
    idle();
    chk("wr_clr_busy", 32'h44, 32'h0, 2'b00, 1'b1);
    tick();

    i_re = 1'b0; i_alloc = 1'b1; i_alloc_rd = 5'd4; rd(5'd4, 5'd3);
    chk("re_off_alloc", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    idle();
    chk("re_off_busy", 32'h0, 32'h0, 2'b01, 1'b1);
    tick();
    i_re = 1'b1; i_alloc = 1'b1; i_alloc_rd = 5'd0; rd(5'd0, 5'd4);
    tick();
    idle();
    chk("alloc_x0_ignored", 32'h0, 32'h0, 2'b10, 1'b1);
    tick();

    wr(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0); rd(5'd9, 5'd7);
    chk("bypass_x9", BYP ? 32'hA5A5A5A5 : 32'h0, 32'h22, 2'b00, 1'b1);
    tick();
    idle();

    for (int i = 1; i < 32; i++) begin
      wr(2'b01, 5'(i), 32'(i) * 32'h01010101, 5'd0, 32'h0);
      tick();
    end
    idle(); i_alloc = 1'b1; i_alloc_rd = 5'd10;
    tick();
    idle(); i_clear = 1'b1; rd(5'd31, 5'd10);
    chk("filled_clear_pulse", 32'h1F1F1F1F, 32'h0A0A0A0A, 2'b10, 1'b1);
    tick();
    idle();
    for (int k = 1; k <= 32; k++) begin
      if (k == 16) begin
        wr(2'b01, 5'd2, 32'hBAD0BAD0, 5'd0, 32'h0);
        i_alloc = 1'b1; i_alloc_rd = 5'd31;
        rd(5'd2, 5'd31);
      end else begin
        idle();
        rd(5'd31, 5'd10);
      end
      chk($sformatf("clearing_%0d", k), 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    idle(); rd(5'd2, 5'd31);
    chk("clear_done", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      rd(5'(2 * i), 5'(2 * i + 1));
      chk($sformatf("after_clear_%0d", i), 32'h0, 32'h0, 2'b00, 1'b1);
      tick();
    end

    wr(2'b01, 5'd2, 32'h77, 5'd0, 32'h0);
    tick();
    wr(2'b01, 5'd31, 32'h99, 5'd0, 32'h0);
    tick();
    idle(); rd(5'd2, 5'd31); i_clear = 1'b1;
    chk("pre_rst_clear", 32'h77, 32'h99, 2'b00, 1'b1);
    tick();
    idle();
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) rst = 1'b1;
      chk($sformatf("rst_clearing_%0d", k), 32'h0, 32'h0, 2'b00, 1'b0);
      tick();
    end
    rst = 1'b0;
    chk("rst_mid_clear", 32'h0, 32'h0, 2'b00, 1'b1);
    tick();
    wr(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
    tick();
    idle(); rd(5'd6, 5'd2);
    chk("post_rst_write", 32'h66, 32'h0, 2'b00, 1'b1);
    tick();

    tick();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
